eight_bit_piso_tx: RTL and testbench
====================================

# eight_bit_piso_tx

Parallel-in serial-out transmitter for 8-bit words held in the team's parallel capture registers. Each accepted byte is shifted out one bit per clock, with a valid qualifier and an end-of-word pulse. The serial side feeds a single-wire link or a downstream serial-in deserialiser. A load handshake allows gapless back-to-back words.

## Interface
Parameters:
- MSB_FIRST, default 0: 0 sends bit 0 first; 1 sends bit 7 first.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- d  input  8  parallel word to transmit; sampled only on an accepted load.
- load_valid  input  1  d holds a word to send.
- load_ready  output  1  the block can accept a word this cycle.
- sdo  output  1  serial data bit.
- sdo_valid  output  1  sdo carries a data or parity bit this cycle.
- done  output  1  one-cycle pulse on the final bit of a word.
- busy  output  1  a word is in flight (SHIFT or PARITY state).

## Operation
- Accept: a load occurs at a rising clk edge when load_valid and load_ready are both 1. On that edge d is copied into shift_reg, bit_cnt is cleared to 0, and the state becomes SHIFT.
- States:
  - IDLE: sdo_valid=0, sdo=0, busy=0.
  - SHIFT: presents shift_reg[0] when MSB_FIRST=0, or shift_reg[7] when MSB_FIRST=1. On each edge the register shifts toward the output end with 0 filled in, and bit_cnt increments.
  - PARITY: present only with PARITY_EN.
- Transitions:
  - SHIFT with bit_cnt=7:
    - To PARITY when PARITY_EN is defined.
    - Otherwise to SHIFT if a load is accepted on that edge, else to IDLE.
  - PARITY: to SHIFT if a load is accepted on that edge, else to IDLE.
- load_ready is 1 in IDLE and in the final-bit cycle. The final-bit cycle is SHIFT with bit_cnt=7 when PARITY_EN is undefined, or the PARITY cycle when it is defined. load_ready is 0 in all other cycles and 0 while rst=1.
- done=1 exactly in the final-bit cycle.
- busy=1 in SHIFT and PARITY.
- load_valid while load_ready=0 is ignored. Changes to d during transmission have no effect.
- bit_cnt is 3 bits wide. It is never read in IDLE.

## Timing
- Latency: the first bit appears on sdo in the cycle after the accepting edge.
- Word duration: 8 cycles, or 9 cycles with PARITY_EN.
- Back-to-back: a load accepted in the final-bit cycle makes the next word's first bit follow with no gap. sdo_valid stays 1 continuously.
- sdo, sdo_valid, done and busy are registered or decoded from registered state only. They have no combinational path from d or load_valid.
- load_ready is decoded from state and is combinational from registers only.
- Reset values, immediate on rst rising and held while rst=1:
  - State IDLE, shift_reg=0, bit_cnt=0.
  - sdo=0, sdo_valid=0, done=0, busy=0, load_ready=0.
- Reset mid-word: the word is abandoned with no done pulse. After rst falls the block idles with load_ready=1 on the first cycle.

## Configuration
- PARITY_EN defined:
  - After the 8 data bits, one extra PARITY cycle drives sdo with the even-parity bit, i.e. the XOR of the 8 bits of the accepted word.
  - The parity bit is captured into a flop at load time.
  - sdo_valid=1 during the PARITY cycle. done and load_ready move to the PARITY cycle.
- PARITY_EN undefined: no PARITY state and no parity flop. Words are 8 cycles and done coincides with the 8th data bit.

## Test plan
- Reset: assert rst mid-clock -> all outputs 0 immediately. Release rst -> load_ready=1, sdo_valid=0.
- Single word LSB-first: load d=8'hA5 -> sdo sequence 1,0,1,0,0,1,0,1 on cycles 1..8 after the accept. done on cycle 8 without PARITY_EN; with PARITY_EN, parity bit 0 on cycle 9 with done.
- MSB_FIRST=1: load d=8'h81 -> sdo 1,0,0,0,0,0,0,1. Then load d=8'h01 -> sdo 0,0,0,0,0,0,0,1 with parity 1 under PARITY_EN.
- Back-to-back: hold load_valid=1 with 8'hFF then 8'h00 -> 16 (or 18) consecutive sdo_valid=1 cycles with no gap, load_ready high only in the final-bit cycles, and 2 done pulses.
- Ignored load and stable input: pulse load_valid with d=8'h3C mid-word and toggle d -> serial stream of the first word is unchanged and 8'h3C is not sent.
- Reset mid-word: assert rst at bit 4 of 8'hF0 -> no done pulse. After release, the next load of 8'h0F transmits cleanly.

Source files
------------

// File: rtl/eight_bit_piso_tx.sv
// eight_bit_piso_tx: parallel-in serial-out transmitter for 8-bit words.
// An accepted byte is shifted out one bit per clock on sdo with sdo_valid,
// and done pulses on the final bit. A new word can be accepted in the
// final-bit cycle, so back-to-back words stream with no gap.
//
// Handshake: a word is taken on a rising clk edge where load_valid and
// load_ready are both 1; load_ready depends only on registered state (and rst),
// never on load_valid or d.
//
// Optional feature macro: PARITY_EN. When defined, each word is followed by
// one PARITY cycle carrying the even-parity bit (XOR of the 8 data bits);
// done and load_ready then move to that cycle.
//
// MSB_FIRST = 0 sends bit 0 first; MSB_FIRST = 1 sends bit 7 first.
module eight_bit_piso_tx #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic       load_valid,
    output logic       load_ready,
    output logic       sdo,
    output logic       sdo_valid,
    output logic       done,
    output logic       busy
);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t     state;
    state_t     state_nxt;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       final_bit;
    logic       accept;

`ifdef PARITY_EN
    logic       par_q;
`endif

    // Final-bit cycle: last data bit, or the parity cycle when parity is on.
`ifdef PARITY_EN
    assign final_bit = (state == PARITY);
`else
    assign final_bit = (state == SHIFT) && (bit_cnt == 3'd7);
`endif

    assign load_ready = !rst && ((state == IDLE) || final_bit);
    assign accept     = load_valid && load_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt == 3'd7) begin
`ifdef PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                state_nxt = accept ? SHIFT : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture the word on accept, otherwise shift toward the output end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
`ifdef PARITY_EN
            par_q     <= 1'b0;
`endif
        end else if (accept) begin
            shift_reg <= d;
            bit_cnt   <= 3'd0;
`ifdef PARITY_EN
            par_q     <= ^d;
`endif
        end else if (state == SHIFT) begin
            if (MSB_FIRST) begin
                shift_reg <= {shift_reg[6:0], 1'b0};
            end else begin
                shift_reg <= {1'b0, shift_reg[7:1]};
            end
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Serial outputs, decoded from registered state only.
    always_comb begin
        sdo       = 1'b0;
        sdo_valid = 1'b0;
        busy      = 1'b0;
        done      = final_bit;
        case (state)
            SHIFT: begin
                sdo       = MSB_FIRST ? shift_reg[7] : shift_reg[0];
                sdo_valid = 1'b1;
                busy      = 1'b1;
            end
`ifdef PARITY_EN
            PARITY: begin
                sdo       = par_q;
                sdo_valid = 1'b1;
                busy      = 1'b1;
            end
`endif
            default: begin
                sdo       = 1'b0;
                sdo_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_eight_bit_piso_tx.sv
// Testbench for eight_bit_piso_tx. Two instances (LSB-first and MSB-first)
// share the same clock, reset and load inputs; a scoreboard queue holds the
// expected per-cycle serial bits for both and is checked every cycle.
module tb_eight_bit_piso_tx;

`ifdef PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] d = 8'h00;
    logic       load_valid = 1'b0;
    logic       load_ready_a, sdo_a, sdo_valid_a, done_a, busy_a;
    logic       load_ready_b, sdo_b, sdo_valid_b, done_b, busy_b;

    eight_bit_piso_tx #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .d(d), .load_valid(load_valid),
        .load_ready(load_ready_a), .sdo(sdo_a), .sdo_valid(sdo_valid_a),
        .done(done_a), .busy(busy_a)
    );

    eight_bit_piso_tx #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .d(d), .load_valid(load_valid),
        .load_ready(load_ready_b), .sdo(sdo_b), .sdo_valid(sdo_valid_b),
        .done(done_b), .busy(busy_b)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;

    // entry = {lsb-first bit, msb-first bit, done}
    logic [2:0] exp_q[$];
    logic [7:0] pend_sl = 8'h00;
    logic [7:0] pend_sm = 8'h00;
    logic       pend_p  = 1'b0;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at %0t: got=%b exp=%b", name, $time, act, expv);
        end
    endtask

    function automatic logic [9:0] outs();
        return {sdo_valid_a, sdo_valid_b, sdo_a, sdo_b, done_a, done_b,
                busy_a, busy_b, load_ready_a, load_ready_b};
    endfunction

    // Streams are in transmission order: bit [7] goes out first.
    task automatic push_word(input logic [7:0] sl, input logic [7:0] sm, input logic p);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({sl[7-i], sm[7-i], (i == 7) && !PAR});
        end
        if (PAR) exp_q.push_back({p, p, 1'b1});
    endtask

    // Per-cycle monitor: compare and pop at #1, then model the accept at #2.
    always @(negedge clk) begin : monitor
        logic       v;
        logic [2:0] f;
        #1;
        if (done_a) done_cnt++;
        if (rst) begin
            exp_q.delete();
            check("reset_hold", outs(), 10'b0);
        end else begin
            v = (exp_q.size() != 0);
            f = v ? exp_q[0] : 3'b000;
            check("stream", outs(),
                  {v, v, f[2], f[1], f[0], f[0], v, v, (!v) | f[0], (!v) | f[0]});
            if (v) void'(exp_q.pop_front());
        end
        #1;
        if (!rst && load_valid && exp_q.size() == 0) begin
            push_word(pend_sl, pend_sm, pend_p);
            acc_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [7:0] w, input logic [7:0] sl,
                             input logic [7:0] sm, input logic p, input bit keep);
        int start;
        int n;
        start = acc_cnt;
        @(negedge clk);
        d = w; load_valid = 1'b1;
        pend_sl = sl; pend_sm = sm; pend_p = p;
        #3;
        n = 0;
        while (acc_cnt == start && n < 40) begin
            @(negedge clk);
            #3;
            n++;
        end
        checks++;
        if (acc_cnt == start) begin
            failures++;
            $display("FAIL accept_timeout word=%h got=not_accepted exp=accepted", w);
        end
        if (!keep) begin
            @(negedge clk);
            load_valid = 1'b0;
            d = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL idle_timeout got=%0d exp=0 pending bits", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = w[i];
        return r;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] d;
        logic [7:0] sl;   // expected LSB-first stream, first bit at [7]
        logic [7:0] sm;   // expected MSB-first stream, first bit at [7]
        logic       p;
        bit         keep; // hold load_valid into the next word
    } vec_t;

    vec_t tbl[6];

    initial begin : stim
        int dc0;
        logic [7:0] w;
        bit kp;

        tbl[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0, 1'b0};
        tbl[1] = '{8'h81, 8'b10000001, 8'b10000001, 1'b0, 1'b0};
        tbl[2] = '{8'h01, 8'b10000000, 8'b00000001, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 8'b11111111, 8'b11111111, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 8'b00000000, 8'b00000000, 1'b0, 1'b0};
        tbl[5] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0, 1'b0};

        // Reset: held at start, released on a falling edge.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        // Asynchronous assertion mid-clock from idle: load_ready drops at once.
        #3 rst = 1'b1;
        #1 check("reset_async_idle", outs(), 10'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven words.
        for (int i = 0; i < 6; i++) begin
            send_word(tbl[i].d, tbl[i].sl, tbl[i].sm, tbl[i].p, tbl[i].keep);
        end
        wait_idle();

        // Back-to-back FF then 00: gapless, exactly two done pulses.
        dc0 = done_cnt;
        send_word(8'hFF, 8'b11111111, 8'b11111111, 1'b0, 1'b1);
        send_word(8'h00, 8'b00000000, 8'b00000000, 1'b0, 1'b0);
        wait_idle();
        check("b2b_done_pulses", 10'(done_cnt - dc0), 10'd2);

        // Ignored load mid-word and d toggling during transmission.
        send_word(8'hA5, 8'b10100101, 8'b10100101, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        d = 8'h3C; load_valid = 1'b1;
        pend_sl = 8'b00111100; pend_sm = 8'b00111100; pend_p = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d = ~d;
        end
        wait_idle();

        // Reset at bit 4 of F0: word abandoned, no done pulse.
        dc0 = done_cnt;
        send_word(8'hF0, 8'b00001111, 8'b11110000, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #3 rst = 1'b1;
        #1 check("reset_async_midword", outs(), 10'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("no_done_on_reset", 10'(done_cnt - dc0), 10'd0);
        send_word(8'h0F, 8'b11110000, 8'b00001111, 1'b0, 1'b0);
        wait_idle();

        // Random words with random back-to-back chaining.
        for (int i = 0; i < 8; i++) begin
            w  = 8'($urandom_range(0, 255));
            kp = (i != 7) && ($urandom_range(0, 1) == 1);
            send_word(w, rev8(w), w, ^w, kp);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
